// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multi-cycle MIPS control FSM.
// The WB_I state exists only when MC_CTRL_ADDI_EN is defined.
`timescale 1ns/1ps
package mc_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_ADDR,
    EXEC_BR,
    EXEC_J,
    MEM_RD,
    MEM_WR,
    WB_R,
    WB_MEM,
    TRAP
`ifdef MC_CTRL_ADDI_EN
    , WB_I
`endif
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] PC_SRC_ALU = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;
  localparam logic [1:0] PC_SRC_J   = 2'b10;

  localparam logic [1:0] SRC_B_RT   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;
  localparam logic [1:0] SRC_B_BR   = 2'b11;

  localparam logic [1:0] FAULT_NONE = 2'b00;
  localparam logic [1:0] FAULT_OP   = 2'b01;
  localparam logic [1:0] FAULT_FUNC = 2'b10;
  localparam logic [1:0] FAULT_TMO  = 2'b11;

  typedef struct packed {
    logic       pcWr;
    logic [1:0] pcSrc;
    logic       irWr;
    logic       iord;
    logic       memRd;
    logic       memWr;
    logic       regWr;
    logic       regDst;
    logic       memToReg;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       extOp;
    logic [2:0] aluCtr;
    logic       instrDone;
  } ctrl_t;

  function automatic logic isMemState(state_t s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: R-type funct to ALU op decoder with a legality flag.
// Unknown funct values decode to ADD with funcLegal low.
`timescale 1ns/1ps
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] func,
  output logic [2:0] aluCtr,
  output logic       funcLegal
);

  always_comb begin
    aluCtr    = ALU_ADD;
    funcLegal = 1'b1;
    unique case (1'b1)
      func == FN_ADD: aluCtr = ALU_ADD;
      func == FN_SUB: aluCtr = ALU_SUB;
      func == FN_AND: aluCtr = ALU_AND;
      func == FN_OR:  aluCtr = ALU_OR;
      func == FN_SLT: aluCtr = ALU_SLT;
      default:        funcLegal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM with memory wait timeout trap.
// Define MC_CTRL_ADDI_EN to accept ADDI (completes through WB_I).
`timescale 1ns/1ps
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ins,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_wr,
  output logic [1:0]  pc_src,
  output logic        ir_wr,
  output logic        iord,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        reg_wr,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        ext_op,
  output logic [2:0]  alu_ctr,
  output logic        instr_done,
  output logic        fault,
  output logic [1:0]  fault_code
);

  logic [5:0] op;
  logic [5:0] func;
  logic       unusedIns;

  assign op        = ins[31:26];
  assign func      = ins[5:0];
  assign unusedIns = ^ins[25:6];

  state_t            state;
  state_t            stateNxt;
  logic [WAIT_W-1:0] waitCnt;
  logic [WAIT_W-1:0] waitNxt;
  logic              faultQ;
  logic [1:0]        codeQ;
  logic [1:0]        codeNxt;
  logic              memState;
  logic              waitHit;
  logic [2:0]        decCtr;
  logic              funcLegal;
  logic              isR;
  logic              immOp;
  logic              memOp;
  ctrl_t             ctrl;

  mc_alu_dec uDec (
    .func      (func),
    .aluCtr    (decCtr),
    .funcLegal (funcLegal)
  );

`ifdef MC_CTRL_ADDI_EN
  assign immOp = (op == OP_ADDI);
`else
  assign immOp = 1'b0;
`endif

  assign isR   = (op == OP_R);
  assign memOp = (op == OP_LW) || (op == OP_SW) || immOp;

  // Ready on the terminal count still wins; only a miss there traps.
  assign memState = isMemState(state);
  assign waitHit  = memState && !mem_ready
                  && (waitCnt == WAIT_W'(WAIT_MAX));
  assign waitNxt  = (memState && !mem_ready && !waitHit)
                  ? waitCnt + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      waitCnt <= '0;
      faultQ  <= 1'b0;
      codeQ   <= FAULT_NONE;
    end else begin
      state   <= stateNxt;
      waitCnt <= waitNxt;
      if (stateNxt == TRAP && state != TRAP) begin
        faultQ <= 1'b1;
        codeQ  <= codeNxt;
      end
    end
  end

  always_comb begin
    stateNxt = state;
    codeNxt  = FAULT_NONE;
    ctrl     = '0;
    unique case (state)
      IDLE: stateNxt = FETCH;
      FETCH: begin
        ctrl.memRd   = 1'b1;
        ctrl.aluSrcB = SRC_B_FOUR;
        ctrl.aluCtr  = ALU_ADD;
        if (mem_ready) begin
          ctrl.irWr  = 1'b1;
          ctrl.pcWr  = 1'b1;
          ctrl.pcSrc = PC_SRC_ALU;
          stateNxt   = DECODE;
        end else if (waitHit) begin
          stateNxt = TRAP;
          codeNxt  = FAULT_TMO;
        end
      end
      DECODE: begin
        ctrl.aluSrcB = SRC_B_BR;
        ctrl.extOp   = 1'b1;
        ctrl.aluCtr  = ALU_ADD;
        unique case (1'b1)
          isR && funcLegal:  stateNxt = EXEC_R;
          isR && !funcLegal: begin
            stateNxt = TRAP;
            codeNxt  = FAULT_FUNC;
          end
          memOp:         stateNxt = EXEC_ADDR;
          op == OP_BEQ:  stateNxt = EXEC_BR;
          op == OP_J:    stateNxt = EXEC_J;
          default: begin
            stateNxt = TRAP;
            codeNxt  = FAULT_OP;
          end
        endcase
      end
      EXEC_R: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRC_B_RT;
        ctrl.aluCtr  = decCtr;
        stateNxt     = WB_R;
      end
      EXEC_ADDR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRC_B_IMM;
        ctrl.extOp   = 1'b1;
        ctrl.aluCtr  = ALU_ADD;
        unique case (1'b1)
          op == OP_SW: stateNxt = MEM_WR;
`ifdef MC_CTRL_ADDI_EN
          immOp:       stateNxt = WB_I;
`endif
          default:     stateNxt = MEM_RD;
        endcase
      end
      EXEC_BR: begin
        ctrl.aluSrcA   = 1'b1;
        ctrl.aluSrcB   = SRC_B_RT;
        ctrl.aluCtr    = ALU_SUB;
        ctrl.pcSrc     = PC_SRC_BR;
        ctrl.pcWr      = zero;
        ctrl.instrDone = 1'b1;
        stateNxt       = FETCH;
      end
      EXEC_J: begin
        ctrl.pcSrc     = PC_SRC_J;
        ctrl.pcWr      = 1'b1;
        ctrl.instrDone = 1'b1;
        stateNxt       = FETCH;
      end
      MEM_RD: begin
        ctrl.memRd = 1'b1;
        ctrl.iord  = 1'b1;
        if (mem_ready) begin
          stateNxt = WB_MEM;
        end else if (waitHit) begin
          stateNxt = TRAP;
          codeNxt  = FAULT_TMO;
        end
      end
      MEM_WR: begin
        ctrl.memWr = 1'b1;
        ctrl.iord  = 1'b1;
        if (mem_ready) begin
          ctrl.instrDone = 1'b1;
          stateNxt       = FETCH;
        end else if (waitHit) begin
          stateNxt = TRAP;
          codeNxt  = FAULT_TMO;
        end
      end
      WB_R: begin
        ctrl.regWr     = 1'b1;
        ctrl.regDst    = 1'b1;
        ctrl.instrDone = 1'b1;
        stateNxt       = FETCH;
      end
      WB_MEM: begin
        ctrl.regWr     = 1'b1;
        ctrl.memToReg  = 1'b1;
        ctrl.instrDone = 1'b1;
        stateNxt       = FETCH;
      end
`ifdef MC_CTRL_ADDI_EN
      WB_I: begin
        ctrl.regWr     = 1'b1;
        ctrl.instrDone = 1'b1;
        stateNxt       = FETCH;
      end
`endif
      TRAP: stateNxt = TRAP;
      default: stateNxt = IDLE;
    endcase
  end

  assign pc_wr      = ctrl.pcWr;
  assign pc_src     = ctrl.pcSrc;
  assign ir_wr      = ctrl.irWr;
  assign iord       = ctrl.iord;
  assign mem_rd     = ctrl.memRd;
  assign mem_wr     = ctrl.memWr;
  assign reg_wr     = ctrl.regWr;
  assign reg_dst    = ctrl.regDst;
  assign mem_to_reg = ctrl.memToReg;
  assign alu_src_a  = ctrl.aluSrcA;
  assign alu_src_b  = ctrl.aluSrcB;
  assign ext_op     = ctrl.extOp;
  assign alu_ctr    = ctrl.aluCtr;
  assign instr_done = ctrl.instrDone;
  assign fault      = faultQ;
  assign fault_code = codeQ;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized scoreboard bench for mc_ctrl.
// Per-instruction expectations are queued and checked on instr_done.
`timescale 1ns/1ps
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] ins = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_wr;
  logic [1:0]  pc_src;
  logic        ir_wr;
  logic        iord;
  logic        mem_rd;
  logic        mem_wr;
  logic        reg_wr;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        ext_op;
  logic [2:0]  alu_ctr;
  logic        instr_done;
  logic        fault;
  logic [1:0]  fault_code;

  always #5 clk = ~clk;

  mc_ctrl #(.WAIT_MAX(15), .WAIT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ins        (ins),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_wr      (pc_wr),
    .pc_src     (pc_src),
    .ir_wr      (ir_wr),
    .iord       (iord),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .reg_wr     (reg_wr),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ext_op     (ext_op),
    .alu_ctr    (alu_ctr),
    .instr_done (instr_done),
    .fault      (fault),
    .fault_code (fault_code)
  );

  logic [17:0] allOut;
  logic [7:0]  finOut;
  assign allOut = {pc_wr, pc_src, ir_wr, iord, mem_rd, mem_wr,
                   reg_wr, reg_dst, mem_to_reg, alu_src_a,
                   alu_src_b, ext_op, alu_ctr, instr_done};
  assign finOut = {pc_wr, pc_src, reg_wr, reg_dst,
                   mem_to_reg, mem_wr, mem_rd};

  typedef struct {
    int cycles;
    int memRd;
    int memWr;
    int irWr;
    int pcWr;
    int regWr;
    int extOp;
    int aluA;
    int aluLast;
    logic [7:0] fin;
  } exp_t;

  localparam int K_R = 0, K_LW = 1, K_SW = 2;
  localparam int K_BEQ = 3, K_J = 4, K_ADDI = 5;

  exp_t q[$];
  int   nCmp = 0;
  int   nBad = 0;
  bit   track = 1'b0;

  function automatic void check(string name, int act, int req);
    nCmp++;
    if (act != req) begin
      nBad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  // Monitor: accumulate per-instruction activity, compare at instr_done.
  initial begin
    int aCyc, aRd, aWr, aIr, aPc, aReg, aExt, aA, aAlu;
    exp_t e;
    aCyc = 0; aRd = 0; aWr = 0; aIr = 0; aPc = 0;
    aReg = 0; aExt = 0; aA = 0; aAlu = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || !track) begin
        aCyc = 0; aRd = 0; aWr = 0; aIr = 0; aPc = 0;
        aReg = 0; aExt = 0; aA = 0; aAlu = 0;
      end else begin
        aCyc++;
        if (mem_rd) aRd++;
        if (mem_wr) aWr++;
        if (ir_wr) aIr++;
        if (pc_wr) aPc++;
        if (reg_wr) aReg++;
        if (ext_op) aExt++;
        if (alu_src_a) begin
          aA++;
          aAlu = int'(alu_ctr);
        end
        if (instr_done) begin
          if (q.size() == 0) begin
            check("spurious_done", 1, 0);
          end else begin
            e = q.pop_front();
            check("latency", aCyc, e.cycles);
            check("mem_rd_cycles", aRd, e.memRd);
            check("mem_wr_cycles", aWr, e.memWr);
            check("ir_wr_cycles", aIr, e.irWr);
            check("pc_wr_cycles", aPc, e.pcWr);
            check("reg_wr_cycles", aReg, e.regWr);
            check("ext_op_cycles", aExt, e.extOp);
            check("alu_a_cycles", aA, e.aluA);
            check("alu_ctr_exec", aAlu, e.aluLast);
            check("final_outputs", int'(finOut), int'(e.fin));
          end
          aCyc = 0; aRd = 0; aWr = 0; aIr = 0; aPc = 0;
          aReg = 0; aExt = 0; aA = 0; aAlu = 0;
        end
      end
    end
  end

  function automatic logic rb();
    return ($urandom() & 1) != 0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    track = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset_outputs", int'(allOut), 0);
    cyc();
    check("reset_fault", int'(fault), 0);
    check("reset_code", int'(fault_code), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    track = 1'b1;
  endtask

  // Issue one legal instruction with fw fetch waits and mw memory waits.
  task automatic runInstr(int kind, int fw, int mw, logic zr);
    int rdy[$];
    exp_t e;
    logic [31:0] r;
    logic [5:0] fnTab[5];
    int fi;
    fnTab[0] = 6'b100000; fnTab[1] = 6'b100010;
    fnTab[2] = 6'b100100; fnTab[3] = 6'b100101;
    fnTab[4] = 6'b101010;
    r  = $urandom();
    fi = $urandom_range(0, 4);
    e.cycles = fw + 2; e.memRd = fw + 1; e.memWr = 0;
    e.irWr = 1; e.pcWr = 1; e.regWr = 0; e.extOp = 1;
    e.aluA = 1; e.aluLast = 0; e.fin = 8'h00;
    repeat (fw) rdy.push_back(0);
    rdy.push_back(1);
    rdy.push_back(int'(rb()));
    case (kind)
      K_R: begin
        ins = {6'b000000, r[19:0], fnTab[fi]};
        e.cycles += 2; e.regWr = 1; e.aluLast = fi;
        e.fin = 8'b0_00_1_1_0_0_0;
        rdy.push_back(int'(rb())); rdy.push_back(int'(rb()));
      end
      K_LW: begin
        ins = {6'b100011, r[25:0]};
        e.cycles += 3 + mw; e.memRd += mw + 1;
        e.regWr = 1; e.extOp = 2;
        e.fin = 8'b0_00_1_0_1_0_0;
        rdy.push_back(int'(rb()));
        repeat (mw) rdy.push_back(0);
        rdy.push_back(1);
        rdy.push_back(int'(rb()));
      end
      K_SW: begin
        ins = {6'b101011, r[25:0]};
        e.cycles += 2 + mw; e.memWr = mw + 1; e.extOp = 2;
        e.fin = 8'b0_00_0_0_0_1_0;
        rdy.push_back(int'(rb()));
        repeat (mw) rdy.push_back(0);
        rdy.push_back(1);
      end
      K_BEQ: begin
        ins = {6'b000100, r[25:0]};
        e.cycles += 1; e.pcWr += zr ? 1 : 0; e.aluLast = 1;
        e.fin = {zr, 2'b01, 5'b0};
        rdy.push_back(int'(rb()));
      end
      K_J: begin
        ins = {6'b000010, r[25:0]};
        e.cycles += 1; e.pcWr += 1; e.aluA = 0;
        e.fin = 8'b1_10_0_0_0_0_0;
        rdy.push_back(int'(rb()));
      end
      default: begin
        ins = {6'b001000, r[25:0]};
        e.cycles += 2; e.regWr = 1; e.extOp = 2;
        e.fin = 8'b0_00_1_0_0_0_0;
        rdy.push_back(int'(rb())); rdy.push_back(int'(rb()));
      end
    endcase
    q.push_back(e);
    foreach (rdy[k]) begin
      mem_ready = (rdy[k] != 0);
      zero = zr;
      cyc();
    end
  endtask

  // Illegal op or funct: trap after DECODE, sticky until reset.
  task automatic trapDecode(logic [31:0] word, int code);
    ins = word;
    mem_ready = 1'b1;
    repeat (4) cyc();
    check("trap_fault", int'(fault), 1);
    check("trap_code", int'(fault_code), code);
    check("trap_outputs", int'(allOut), 0);
    mem_ready = rb();
    repeat (10) cyc();
    check("trap_hold_fault", int'(fault), 1);
    check("trap_hold_code", int'(fault_code), code);
    doReset();
  endtask

  task automatic randomRun(int n);
    int kind;
    int fw;
    int mw;
    for (int i = 0; i < n; i++) begin
`ifdef MC_CTRL_ADDI_EN
      kind = $urandom_range(0, 5);
`else
      kind = $urandom_range(0, 4);
`endif
      fw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 0;
      mw = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : 0;
      runInstr(kind, fw, mw, rb());
    end
  endtask

  initial begin
    #2;
    doReset();

    runInstr(K_R, 0, 0, 1'b0);
    runInstr(K_LW, 0, 3, 1'b0);
    runInstr(K_BEQ, 0, 0, 1'b1);
    runInstr(K_BEQ, 0, 0, 1'b0);
    runInstr(K_J, 0, 0, 1'b0);
    runInstr(K_SW, 15, 15, 1'b0);
    runInstr(K_LW, 15, 15, 1'b1);
`ifdef MC_CTRL_ADDI_EN
    runInstr(K_ADDI, 0, 0, 1'b0);
`endif
    randomRun(200);

    trapDecode({6'b111111, 20'h12345, 6'b100000}, 1);
    trapDecode({6'b000000, 20'h0abcd, 6'b000111}, 2);
`ifndef MC_CTRL_ADDI_EN
    trapDecode({6'b001000, 26'h0001234}, 1);
`endif

    // Fetch timeout: 15 missed cycles still wait, the 16th traps.
    ins = {6'b000000, 20'h0, 6'b100000};
    mem_ready = 1'b0;
    repeat (15) cyc();
    check("tmo_pre_fault", int'(fault), 0);
    check("tmo_pre_mem_rd", int'(mem_rd), 1);
    cyc();
    check("tmo_fault", int'(fault), 1);
    check("tmo_code", int'(fault_code), 3);
    check("tmo_mem_rd", int'(mem_rd), 0);
    repeat (5) cyc();
    check("tmo_hold_code", int'(fault_code), 3);
    doReset();

    // Reset during MEM_WR: request drops immediately, no write-back.
    ins = {6'b101011, 26'h0000040};
    mem_ready = 1'b1;
    repeat (3) cyc();
    mem_ready = 1'b0;
    repeat (2) cyc();
    check("sw_mid_mem_wr", int'(mem_wr), 1);
    check("sw_mid_iord", int'(iord), 1);
    doReset();
    check("post_rst_reg_wr", int'(reg_wr), 0);

    randomRun(100);

    repeat (3) cyc();
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

endmodule
